// File: rtl/mc_main_control.sv
// ============================================================================
// Module   : mc_main_control
// Brief    : Main control FSM of the multi-cycle MIPS core. It steps each
//            instruction through fetch, decode, execute, memory and writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       InstrDone,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_pcwrite;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        IorD       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        w_regwrite = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        InstrDone  = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcB   = 2'b01;
            end
            S_DECODE: begin
                // ALU speculatively forms PC + (SignImm << 2) for a branch
                ALUSrcB = 2'b11;
                if (Op == OP_LW || Op == OP_SW) begin
                    w_next = S_MEMADR;
                end else if (Op == OP_RTYPE) begin
                    w_next = S_EXECUTE;
                end else if (Op == OP_BEQ) begin
                    w_next = S_BRANCH;
                end else if (Op == OP_ADDI) begin
                    w_next = S_ADDIEX;
                end else if (Op == OP_J) begin
                    w_next = S_JUMP;
                end else begin
                    w_next    = S_FETCH;
                    InstrDone = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (Op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                IorD   = 1'b1;
            end
            S_MEMWB: begin
                w_next     = S_FETCH;
                w_regwrite = 1'b1;
                MemtoReg   = 1'b1;
                InstrDone  = 1'b1;
            end
            S_MEMWR: begin
                w_next     = S_FETCH;
                IorD       = 1'b1;
                w_memwrite = 1'b1;
                InstrDone  = 1'b1;
            end
            S_EXECUTE: begin
                w_next  = S_ALUWB;
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                w_next     = S_FETCH;
                w_regwrite = 1'b1;
                RegDst     = 1'b1;
                InstrDone  = 1'b1;
            end
            S_BRANCH: begin
                w_next    = S_FETCH;
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b01;
                PCSrc     = 2'b01;
                w_branch  = 1'b1;
                InstrDone = 1'b1;
            end
            S_ADDIEX: begin
                w_next  = S_ADDIWB;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                w_next     = S_FETCH;
                w_regwrite = 1'b1;
                InstrDone  = 1'b1;
            end
            S_JUMP: begin
                w_next    = S_FETCH;
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
                InstrDone = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // State is already FETCH during reset; only the write strobes need gating
    assign MemWrite = w_memwrite & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign PCEn     = (w_pcwrite | (w_branch & Zero)) & ~reset;
    assign State    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_main_control.sv
// ============================================================================
// Module   : tb_mc_main_control
// Brief    : Directed vector bench for mc_main_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_main_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, InstrDone;
    logic [3:0] State;

    mc_main_control dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Zero      (Zero),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .PCEn      (PCEn),
        .InstrDone (InstrDone),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] c_rtype = 6'b000000;
    localparam logic [5:0] c_lw    = 6'b100011;
    localparam logic [5:0] c_sw    = 6'b101011;
    localparam logic [5:0] c_beq   = 6'b000100;
    localparam logic [5:0] c_addi  = 6'b001000;
    localparam logic [5:0] c_j     = 6'b000010;
    localparam logic [5:0] c_unk   = 6'b111111;

    // Packing: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //           ALUSrcB,ALUOp,PCSrc,PCEn,InstrDone,State}
    localparam logic [18:0] c_rst    = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0};
    localparam logic [18:0] c_fetch  = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0};
    localparam logic [18:0] c_decode = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1};
    localparam logic [18:0] c_dec_nop= {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1};
    localparam logic [18:0] c_memadr = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 4'd2};
    localparam logic [18:0] c_memrd  = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3};
    localparam logic [18:0] c_memwb  = {7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'd4};
    localparam logic [18:0] c_memwr  = {7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'd5};
    localparam logic [18:0] c_exec   = {7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 4'd6};
    localparam logic [18:0] c_aluwb  = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'd7};
    localparam logic [18:0] c_br_z1  = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 4'd8};
    localparam logic [18:0] c_br_z0  = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 4'd8};
    localparam logic [18:0] c_addiex = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 4'd9};
    localparam logic [18:0] c_addiwb = {7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 4'd10};
    localparam logic [18:0] c_jump   = {7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 4'd11};

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_miscompares;

    function automatic logic [18:0] outs();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCEn, InstrDone, State};
    endfunction

    task automatic add(input string name, input logic rst, input logic [5:0] op,
                       input logic zero, input logic [18:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.zero = zero; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] act;
        act = outs();
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, act[3:0], act, exp[3:0], exp);
        end
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        reset = 1'b1;
        Op    = c_rtype;
        Zero  = 1'b1;

        add("reset0",      1'b1, c_lw,    1'b1, c_rst);
        add("reset1",      1'b1, c_lw,    1'b1, c_rst);
        add("lw_fetch",    1'b0, c_lw,    1'b1, c_fetch);
        add("lw_decode",   1'b0, c_lw,    1'b1, c_decode);
        add("lw_memadr",   1'b0, c_lw,    1'b1, c_memadr);
        add("lw_memrd",    1'b0, c_lw,    1'b1, c_memrd);
        add("lw_memwb",    1'b0, c_lw,    1'b1, c_memwb);
        add("r_fetch",     1'b0, c_rtype, 1'b1, c_fetch);
        add("r_decode",    1'b0, c_rtype, 1'b1, c_decode);
        add("r_execute",   1'b0, c_rtype, 1'b1, c_exec);
        add("r_aluwb",     1'b0, c_rtype, 1'b1, c_aluwb);
        add("beq1_fetch",  1'b0, c_beq,   1'b1, c_fetch);
        add("beq1_decode", 1'b0, c_beq,   1'b1, c_decode);
        add("beq1_branch", 1'b0, c_beq,   1'b1, c_br_z1);
        add("beq0_fetch",  1'b0, c_beq,   1'b0, c_fetch);
        add("beq0_decode", 1'b0, c_beq,   1'b0, c_decode);
        add("beq0_branch", 1'b0, c_beq,   1'b0, c_br_z0);
        add("sw_fetch",    1'b0, c_sw,    1'b1, c_fetch);
        add("sw_decode",   1'b0, c_sw,    1'b1, c_decode);
        add("sw_memadr",   1'b0, c_sw,    1'b1, c_memadr);
        add("sw_memwr",    1'b0, c_sw,    1'b1, c_memwr);
        add("j_fetch",     1'b0, c_j,     1'b1, c_fetch);
        add("j_decode",    1'b0, c_j,     1'b1, c_decode);
        add("j_jump",      1'b0, c_j,     1'b1, c_jump);
        add("unk_fetch",   1'b0, c_unk,   1'b1, c_fetch);
        add("unk_decode",  1'b0, c_unk,   1'b1, c_dec_nop);
        add("addi_fetch",  1'b0, c_addi,  1'b1, c_fetch);
        add("addi_decode", 1'b0, c_addi,  1'b1, c_decode);
        add("addi_ex",     1'b0, c_addi,  1'b1, c_addiex);
        add("addi_wb",     1'b0, c_addi,  1'b1, c_addiwb);
        add("r2_fetch",    1'b0, c_rtype, 1'b1, c_fetch);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            Op    = vecs[i].op;
            Zero  = vecs[i].zero;
            #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset between edges while in EXECUTE
        @(negedge clk); #1;
        check("ar_decode", c_decode);
        @(negedge clk); #1;
        check("ar_execute", c_exec);
        #2;
        reset = 1'b1;
        #1;
        check("ar_async", c_rst);
        @(negedge clk); #1;
        check("ar_held", c_rst);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_fetch", c_fetch);
        @(negedge clk); #1;
        check("ar_after", c_decode);

        // Reset while in MEMWR must suppress the store strobe immediately
        Op = c_sw;
        @(negedge clk); #1;
        check("rw_memadr", c_memadr);
        @(negedge clk); #1;
        check("rw_memwr", c_memwr);
        #1;
        reset = 1'b1;
        #1;
        check("rw_async", c_rst);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rw_fetch", c_fetch);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire
